// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared definitions for the 4x4 two-stage DCT engine:
//   - FSM state encoding (state_e)
//   - transform direction encoding (mode_e)
//   - fixed Q1.7 coefficient matrix C, served by coef(row, col)
//   - fixed-point scaling constant (divide by 128)
// No ports; imported by dct2d_engine and dct_mac4.
// -----------------------------------------------------------------------------
package dct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INPUT  = 2'd1,
    ST_CALC   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } mode_e;

  localparam int COEF_W    = 8;
  localparam int DIV_CONST = 128;
  localparam int DIV_SHIFT = $clog2(DIV_CONST);
  localparam int BLK_N     = 16;

  // C[r][c] in Q1.7: rows {64,64,64,64} {83,34,-34,-83} {64,-64,-64,64} {34,-83,83,-34}
  function automatic logic signed [COEF_W-1:0] coef(input logic [1:0] r, input logic [1:0] c);
    logic signed [COEF_W-1:0] v;
    case ({r, c})
      4'd0:    v = 8'sd64;
      4'd1:    v = 8'sd64;
      4'd2:    v = 8'sd64;
      4'd3:    v = 8'sd64;
      4'd4:    v = 8'sd83;
      4'd5:    v = 8'sd34;
      4'd6:    v = -8'sd34;
      4'd7:    v = -8'sd83;
      4'd8:    v = 8'sd64;
      4'd9:    v = -8'sd64;
      4'd10:   v = -8'sd64;
      4'd11:   v = 8'sd64;
      4'd12:   v = 8'sd34;
      4'd13:   v = -8'sd83;
      4'd14:   v = 8'sd83;
      4'd15:   v = -8'sd34;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dct_mac4.sv
// -----------------------------------------------------------------------------
// dct_mac4
// Combinational 4-term dot product with Q1.7 rescale and saturation.
//   a_i[4]   : signed data operands (A_W bits)
//   c_i[4]   : signed Q1.7 coefficients
//   narrow_i : 0 -> saturate to OUT_W+2 bits, 1 -> saturate to OUT_W bits
//   res_o    : saturated result, OUT_W+2 bits (narrow results sign-extended)
// The sum is kept at full precision, then divided by 128 truncating toward
// zero (bias negative sums by 127 before the arithmetic shift).
// -----------------------------------------------------------------------------
module dct_mac4
  import dct_pkg::*;
#(
  parameter int A_W   = 12,
  parameter int OUT_W = 10
) (
  input  logic signed [A_W-1:0]    a_i [4],
  input  logic signed [COEF_W-1:0] c_i [4],
  input  logic                     narrow_i,
  output logic signed [OUT_W+1:0]  res_o
);

  localparam int PW   = A_W + COEF_W;
  localparam int SUMW = PW + 2;
  localparam int SW   = OUT_W + 2;

  localparam logic signed [SUMW-1:0] MAX_W = SUMW'((2 ** (SW - 1)) - 1);
  localparam logic signed [SUMW-1:0] MIN_W = SUMW'(-(2 ** (SW - 1)));
  localparam logic signed [SUMW-1:0] MAX_N = SUMW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUMW-1:0] MIN_N = SUMW'(-(2 ** (OUT_W - 1)));

  logic signed [PW-1:0]   prod_s [4];
  logic signed [SUMW-1:0] sum_s;
  logic signed [SUMW-1:0] bias_s;
  logic signed [SUMW-1:0] quot_s;

  // Four signed products; operands widened first so the product is exact.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      prod_s[k] = PW'(a_i[k]) * PW'(c_i[k]);
    end
  end

  // Full-precision sum, then divide by 128 rounding toward zero.
  always_comb begin
    sum_s = {SUMW{1'b0}};
    for (int k = 0; k < 4; k++) begin
      sum_s = sum_s + SUMW'(prod_s[k]);
    end
    if (sum_s[SUMW-1]) begin
      bias_s = SUMW'(DIV_CONST - 1);
    end else begin
      bias_s = {SUMW{1'b0}};
    end
    quot_s = (sum_s + bias_s) >>> DIV_SHIFT;
  end

  // Clip to the selected signed range; never wrap.
  always_comb begin
    res_o = quot_s[SW-1:0];
    if (narrow_i) begin
      if (quot_s > MAX_N) begin
        res_o = SW'(MAX_N);
      end else if (quot_s < MIN_N) begin
        res_o = SW'(MIN_N);
      end else begin
        res_o = quot_s[SW-1:0];
      end
    end else begin
      if (quot_s > MAX_W) begin
        res_o = SW'(MAX_W);
      end else if (quot_s < MIN_W) begin
        res_o = SW'(MIN_W);
      end else begin
        res_o = quot_s[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/dct2d_engine.sv
// -----------------------------------------------------------------------------
// dct2d_engine
// 4x4 separable 2-D DCT / IDCT with Q1.7 coefficients, one MAC per cycle.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready: sample handshake, 16 samples per frame, row-major
//   in_data          : signed IN_W-bit sample
//   mode             : 0 forward (C*X*C^T), 1 inverse (C^T*Y*C); taken with
//                      the first sample of a frame
//   out_valid/out_data: 16 registered signed OUT_W-bit results, row-major,
//                      out_data is 0 when out_valid is 0
//   frame_err        : one-cycle pulse when a frame is truncated
// Timing: last sample at edge k -> results after edges k+33..k+48, ready
// again after edge k+49. CALC is 16 stage-1 cycles then 16 stage-2 cycles.
// -----------------------------------------------------------------------------
module dct2d_engine
  import dct_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    mode,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    frame_err
);

  localparam int SW = OUT_W + 2;
  localparam int DW = (IN_W > SW) ? IN_W : SW;

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  mode_e                   mode_q, mode_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    frame_err_q, frame_err_d;

  logic x_we_s, t_we_s, y_we_s;

  logic signed [IN_W-1:0]  xbuf_q [BLK_N];
  logic signed [SW-1:0]    tbuf_q [BLK_N];
  logic signed [OUT_W-1:0] ybuf_q [BLK_N];

  logic [1:0]               row_s, col_s;
  logic                     stage2_s;
  logic signed [DW-1:0]     mac_a_s [4];
  logic signed [COEF_W-1:0] mac_c_s [4];
  logic signed [SW-1:0]     mac_res_s;

  // Operand select: stage 1 walks a column of X, stage 2 walks a row of T.
  always_comb begin
    row_s    = cnt_q[3:2];
    col_s    = cnt_q[1:0];
    stage2_s = cnt_q[4];
    for (int k = 0; k < 4; k++) begin
      if (stage2_s) begin
        mac_a_s[k] = DW'(tbuf_q[{row_s, 2'(k)}]);
        if (mode_q == MODE_FWD) begin
          mac_c_s[k] = coef(col_s, 2'(k));   // T * C^T
        end else begin
          mac_c_s[k] = coef(2'(k), col_s);   // T * C
        end
      end else begin
        mac_a_s[k] = DW'(xbuf_q[{2'(k), col_s}]);
        if (mode_q == MODE_FWD) begin
          mac_c_s[k] = coef(row_s, 2'(k));   // C * X
        end else begin
          mac_c_s[k] = coef(2'(k), row_s);   // C^T * X
        end
      end
    end
  end

  dct_mac4 #(
    .A_W   (DW),
    .OUT_W (OUT_W)
  ) u_mac (
    .a_i      (mac_a_s),
    .c_i      (mac_c_s),
    .narrow_i (stage2_s),
    .res_o    (mac_res_s)
  );

  // Next-state, counter, buffer-write strobes and next output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    frame_err_d = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = {OUT_W{1'b0}};
    x_we_s      = 1'b0;
    t_we_s      = 1'b0;
    y_we_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_we_s  = 1'b1;
          mode_d  = mode_e'(mode);
          cnt_d   = 5'd1;
          state_d = ST_INPUT;
        end else begin
          cnt_d   = 5'd0;
        end
      end
      ST_INPUT: begin
        if (in_valid) begin
          x_we_s = 1'b1;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            state_d = ST_CALC;
          end else begin
            cnt_d   = cnt_q + 5'd1;
          end
        end else begin
          // Gap inside a frame: drop the partial block.
          cnt_d       = 5'd0;
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end
      end
      ST_CALC: begin
        if (cnt_q[4]) begin
          y_we_s = 1'b1;
        end else begin
          t_we_s = 1'b1;
        end
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = ST_OUTPUT;
        end else begin
          cnt_d   = cnt_q + 5'd1;
        end
      end
      ST_OUTPUT: begin
        // Count 16 is a trailing cycle that keeps in_ready low one more edge.
        if (cnt_q == 5'd16) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = ybuf_q[cnt_q[3:0]];
          cnt_d       = cnt_q + 5'd1;
        end
      end
      default: begin
        cnt_d   = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_INPUT);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      mode_q      <= MODE_FWD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample, intermediate and result buffers, indexed by the running counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_N; i++) begin
        xbuf_q[i] <= {IN_W{1'b0}};
        tbuf_q[i] <= {SW{1'b0}};
        ybuf_q[i] <= {OUT_W{1'b0}};
      end
    end else begin
      if (x_we_s) begin
        xbuf_q[cnt_q[3:0]] <= in_data;
      end
      if (t_we_s) begin
        tbuf_q[cnt_q[3:0]] <= mac_res_s;
      end
      if (y_we_s) begin
        ybuf_q[cnt_q[3:0]] <= mac_res_s[OUT_W-1:0];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule
